text_buffer_ctrl: RTL and testbench
===================================

TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 SHALL provide parameter COLS, default 80, characters per text row.
REQ-002 SHALL provide parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL provide parameter DATA_W, default 32, cell and bus word width.
REQ-004 SHALL provide parameter BASE_ADDR, default 32'h0000_1000, byte address of cell 0.
REQ-005 SHALL provide parameter FILL, default 32'h0000_0020 (space), value written by clear.
REQ-006 SHALL provide parameter BLINK_DIV, default 25_000_000, cycles per cursor blink half-period.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 mem_write  input  1  CPU write strobe.
REQ-010 addr  input  32  CPU byte address.
REQ-011 wdata  input  DATA_W  CPU write data.
REQ-012 rdata  output  DATA_W  CPU read data, registered.
REQ-013 busy  output  1  clear sweep in progress.
REQ-014 vga_rd_en  input  1  display fetch request.
REQ-015 vga_col  input  $clog2(COLS)  display column.
REQ-016 vga_row  input  $clog2(ROWS)  display row (screen-relative).
REQ-017 vga_char  output  DATA_W  fetched cell value.
REQ-018 vga_valid  output  1  vga_char valid strobe.
REQ-019 cursor_hit  output  1  fetched cell is cursor and blink phase on.

Function
REQ-020 Map: N=COLS*ROWS; cell i at BASE_ADDR+4*i; CTRL at BASE_ADDR+4*N; SCROLL at +4*(N+1); CURSOR at +4*(N+2); other addresses ignored, read 0.
REQ-021 Cell i SHALL be stored at physical row i/COLS, column i%COLS.
REQ-022 CPU read: rdata SHALL present addressed word one cycle after addr applied (latency 1), every cycle.
REQ-023 CPU cell write with mem_write=1 SHALL update cell on that edge; visible to both ports next cycle.
REQ-024 Write CTRL with wdata[0]=1 SHALL move FSM IDLE->CLEAR; CTRL reads {busy} in bit 0.
REQ-025 CLEAR: one cell per cycle, index 0..N-1 written FILL; after cell N-1, return IDLE; busy high exactly N cycles starting cycle after CTRL write.
REQ-026 During CLEAR, CPU cell writes SHALL be dropped; further CTRL clear writes ignored (no restart); SCROLL/CURSOR writes accepted.
REQ-027 SCROLL write: value < ROWS SHALL load scroll[$clog2(ROWS)-1:0]; value >= ROWS ignored, old value kept.
REQ-028 Display fetch: physical row = (vga_row + scroll) mod ROWS, wrap-around without overflow for any legal inputs.
REQ-029 vga_valid SHALL equal vga_rd_en delayed one cycle; vga_char valid in that cycle.
REQ-030 vga_col >= COLS or vga_row >= ROWS SHALL return FILL; during CLEAR fetches SHALL return FILL.
REQ-031 Same-cycle CPU write and display fetch of same cell SHALL return old value (read-before-write).

Reset
REQ-032 reset SHALL asynchronously force FSM IDLE, busy=0, scroll=0, cursor=0, blink phase=0, rdata=0, vga_char=0, vga_valid=0, cursor_hit=0.
REQ-033 Cell contents SHALL NOT be reset; reset mid-CLEAR aborts sweep, remaining cells keep prior values.

Configuration
REQ-034 Macro TEXT_BUFFER_CURSOR_BLINK_EN defined: CURSOR register (cell index, < N accepted, else ignored) and blink counter toggling phase every BLINK_DIV cycles SHALL exist; cursor_hit=1 with vga_valid when fetched logical index equals cursor and phase=1.
REQ-035 Macro undefined: no counter or register; cursor_hit constant 0; CURSOR reads 0, writes ignored.

Verification
REQ-036 Write 32'h41 to BASE_ADDR+4*5, read back -> rdata=32'h41 one cycle later; fetch row0 col5 -> vga_char=32'h41, vga_valid 1 cycle after vga_rd_en.
REQ-037 COLS=80,ROWS=30: write CTRL=1 -> busy high exactly 2400 cycles; all cells then read 32'h20; cell write during sweep dropped.
REQ-038 SCROLL=29, fetch vga_row=1 -> returns physical row 0 contents; SCROLL=30 -> scroll stays 29.
REQ-039 Assert reset at sweep cycle 100 -> busy=0 immediately, cells 100..2399 unchanged.
REQ-040 With TEXT_BUFFER_CURSOR_BLINK_EN, BLINK_DIV=4, CURSOR=10: fetch cell 10 -> cursor_hit alternates every 4 cycles; without macro cursor_hit stays 0.

Source files
------------

// File: rtl/text_buffer_ctrl_if.sv
// Bus bundle for text_buffer_ctrl: CPU word port plus display fetch port.
// master = CPU/display side, slave = buffer controller.
interface text_buffer_ctrl_if #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned XW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  logic              mem_write;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              vga_rd_en;
  logic [XW-1:0]     vga_col;
  logic [RW-1:0]     vga_row;
  logic [DATA_W-1:0] vga_char;
  logic              vga_valid;
  logic              cursor_hit;

  modport master (
    output mem_write, addr, wdata, vga_rd_en, vga_col, vga_row,
    input  rdata, busy, vga_char, vga_valid, cursor_hit
  );

  modport slave (
    input  mem_write, addr, wdata, vga_rd_en, vga_col, vga_row,
    output rdata, busy, vga_char, vga_valid, cursor_hit
  );
endinterface

// File: rtl/text_buffer_ctrl.sv
// Text cell buffer: CPU word port, display fetch with scroll, hardware clear sweep.
// Define TEXT_BUFFER_CURSOR_BLINK_EN to add the CURSOR register and blink counter.
//   state | meaning
//   IDLE  | normal CPU and display access
//   CLEAR | one cell per cycle written with FILL, index 0..N-1; CPU cell writes dropped
module text_buffer_ctrl #(
  parameter int unsigned       COLS      = 80,
  parameter int unsigned       ROWS      = 30,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [31:0]       BASE_ADDR = 32'h0000_1000,
  parameter logic [DATA_W-1:0] FILL      = DATA_W'(32'h0000_0020),
  parameter int unsigned       BLINK_DIV = 25_000_000
) (
  input logic               clk,
  input logic               reset,
  text_buffer_ctrl_if.slave bus
);
  localparam int unsigned N   = COLS * ROWS;
  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned RW1 = RW + 1;
  localparam int unsigned XW1 = $clog2(COLS) + 1;
  localparam logic [RW1-1:0] ROWS_X = RW1'(ROWS);
  localparam logic [XW1-1:0] COLS_X = XW1'(COLS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] r_mem [N];
  logic [0:0]        r_state;
  logic [CW-1:0]     r_clr_idx;
  logic [RW-1:0]     r_scroll;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_vga_char;
  logic              r_vga_valid;

  logic [31:0]       w_off;
  logic [29:0]       w_word;
  logic              w_addr_ok;
  logic              w_is_cell;
  logic              w_is_ctrl;
  logic              w_is_scroll;
  logic              w_is_cursor;
  logic [CW-1:0]     w_cpu_idx;
  logic              w_busy;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_cursor_rd;
  logic [RW1-1:0]    w_row_sum;
  logic [RW-1:0]     w_phys_row;
  logic              w_disp_ok;
  logic [CW-1:0]     w_disp_idx;

  // Register window sits right after the last cell: CTRL, SCROLL, CURSOR.
  assign w_off       = bus.addr - BASE_ADDR;
  assign w_word      = w_off[31:2];
  assign w_addr_ok   = (bus.addr >= BASE_ADDR) && (w_off[1:0] == 2'b00);
  assign w_is_cell   = w_addr_ok && (w_word < 30'(N));
  assign w_is_ctrl   = w_addr_ok && (w_word == 30'(N));
  assign w_is_scroll = w_addr_ok && (w_word == 30'(N + 1));
  assign w_is_cursor = w_addr_ok && (w_word == 30'(N + 2));
  assign w_cpu_idx   = w_word[CW-1:0];
  assign w_busy      = (r_state == ST_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_write && w_is_ctrl && bus.wdata[0]) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_idx == CW'(N - 1)) r_state <= ST_IDLE;
          r_clr_idx <= r_clr_idx + CW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scroll <= '0;
    end else if (bus.mem_write && w_is_scroll && (bus.wdata < DATA_W'(ROWS))) begin
      r_scroll <= bus.wdata[RW-1:0];
    end
  end

  // Cell storage is deliberately not reset; an aborted sweep leaves the tail intact.
  always_ff @(posedge clk) begin
    if (w_busy) r_mem[r_clr_idx] <= FILL;
    else if (bus.mem_write && w_is_cell) r_mem[w_cpu_idx] <= bus.wdata;
  end

  always_comb begin
    w_rd_word = '0;
    if (w_is_cell)        w_rd_word = r_mem[w_cpu_idx];
    else if (w_is_ctrl)   w_rd_word = DATA_W'(w_busy);
    else if (w_is_scroll) w_rd_word = DATA_W'(r_scroll);
    else if (w_is_cursor) w_rd_word = w_cursor_rd;
  end

  // Both operands are below ROWS, so a single conditional subtract wraps the sum.
  assign w_row_sum  = {1'b0, bus.vga_row} + {1'b0, r_scroll};
  assign w_phys_row = (w_row_sum >= ROWS_X) ? RW'(w_row_sum - ROWS_X) : w_row_sum[RW-1:0];
  assign w_disp_ok  = ({1'b0, bus.vga_row} < ROWS_X) && ({1'b0, bus.vga_col} < COLS_X);
  assign w_disp_idx = CW'(w_phys_row) * CW'(COLS) + CW'(bus.vga_col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata     <= '0;
      r_vga_char  <= '0;
      r_vga_valid <= 1'b0;
    end else begin
      r_rdata     <= w_rd_word;
      r_vga_valid <= bus.vga_rd_en;
      if (bus.vga_rd_en) r_vga_char <= (w_busy || !w_disp_ok) ? FILL : r_mem[w_disp_idx];
    end
  end

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  logic [CW-1:0] r_cursor;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          r_cursor_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cursor     <= '0;
      r_blink_cnt  <= BW'(BLINK_DIV - 1);
      r_phase      <= 1'b0;
      r_cursor_hit <= 1'b0;
    end else begin
      if (bus.mem_write && w_is_cursor && (bus.wdata < DATA_W'(N))) r_cursor <= bus.wdata[CW-1:0];
      if (r_blink_cnt == '0) begin
        r_blink_cnt <= BW'(BLINK_DIV - 1);
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt - BW'(1);
      end
      r_cursor_hit <= bus.vga_rd_en && w_disp_ok && (w_disp_idx == r_cursor) && r_phase;
    end
  end

  assign w_cursor_rd    = DATA_W'(r_cursor);
  assign bus.cursor_hit = r_cursor_hit;
`else
  assign w_cursor_rd    = '0;
  assign bus.cursor_hit = 1'b0;
`endif

  assign bus.rdata     = r_rdata;
  assign bus.busy      = w_busy;
  assign bus.vga_char  = r_vga_char;
  assign bus.vga_valid = r_vga_valid;
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: array-based reference model, per-cycle
// compare, directed literal checks plus randomized CPU/display traffic.
module tb_text_buffer_ctrl;
  localparam int          COLS  = 80;
  localparam int          ROWS  = 30;
  localparam int          N     = COLS * ROWS;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] FILLV = 32'h0000_0020;
  localparam int          BDIV  = 4;
  localparam logic [31:0] A_CTRL   = BASE + 32'(4 * N);
  localparam logic [31:0] A_SCROLL = BASE + 32'(4 * (N + 1));
  localparam logic [31:0] A_CURSOR = BASE + 32'(4 * (N + 2));
`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  text_buffer_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .DATA_W(32)) bus ();

  text_buffer_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DATA_W(32), .BASE_ADDR(BASE), .FILL(FILLV), .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_cell  [N];
  bit          m_known [N];
  bit          m_clearing = 0;
  int          m_clr_pos = 0;
  int          m_scroll = 0;
  int          m_cursor = 0;
  bit          m_phase = 0;
  int          m_edges = 0;
  logic [31:0] e_rdata = 0;
  bit          e_rdata_known = 1;
  bit          e_valid = 0;
  logic [31:0] e_char = 0;
  bit          e_char_known = 1;
  bit          e_hit = 0;

  function automatic int word_of(logic [31:0] a);
    if (a < BASE || a[1:0] != 2'b00) return -1;
    return int'((a - BASE) >> 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_clearing = 0; m_scroll = 0; m_cursor = 0; m_phase = 0; m_edges = 0;
      e_rdata = 0; e_rdata_known = 1; e_valid = 0; e_char = 0; e_char_known = 1; e_hit = 0;
    end else begin
      int  w, r, c, idx;
      bit  was_clear;
      w = word_of(bus.addr);
      was_clear = m_clearing;
      e_rdata = 0; e_rdata_known = 1;
      if (w >= 0 && w < N) begin e_rdata = m_cell[w]; e_rdata_known = m_known[w]; end
      else if (w == N)     e_rdata = 32'(m_clearing);
      else if (w == N + 1) e_rdata = 32'(m_scroll);
      else if (w == N + 2) e_rdata = CUR_EN ? 32'(m_cursor) : 32'd0;
      e_valid = bus.vga_rd_en;
      if (bus.vga_rd_en) begin
        r = int'(bus.vga_row); c = int'(bus.vga_col);
        e_hit = 0; e_char_known = 1;
        if (r >= ROWS || c >= COLS) begin
          e_char = FILLV;
        end else begin
          idx = ((r + m_scroll) % ROWS) * COLS + c;
          e_hit = CUR_EN && (idx == m_cursor) && m_phase;
          if (m_clearing) e_char = FILLV;
          else begin e_char = m_cell[idx]; e_char_known = m_known[idx]; end
        end
      end
      if (m_clearing) begin
        m_cell[m_clr_pos] = FILLV; m_known[m_clr_pos] = 1; m_clr_pos++;
        if (m_clr_pos == N) m_clearing = 0;
      end else if (bus.mem_write && w >= 0 && w < N) begin
        m_cell[w] = bus.wdata; m_known[w] = 1;
      end
      if (bus.mem_write && w == N && bus.wdata[0] && !was_clear) begin
        m_clearing = 1; m_clr_pos = 0;
      end
      if (bus.mem_write && w == N + 1 && bus.wdata < 32'(ROWS)) m_scroll = int'(bus.wdata);
      if (bus.mem_write && w == N + 2 && bus.wdata < 32'(N)) m_cursor = int'(bus.wdata);
      m_edges++;
      if (m_edges == BDIV) begin m_edges = 0; m_phase = ~m_phase; end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (e_rdata_known) check("rdata", bus.rdata, e_rdata);
      check("busy", 32'(bus.busy), 32'(m_clearing));
      check("vga_valid", 32'(bus.vga_valid), 32'(e_valid));
      if (e_valid) begin
        if (e_char_known) check("vga_char", bus.vga_char, e_char);
        check("cursor_hit", 32'(bus.cursor_hit), 32'(e_hit));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    tick();
    d = bus.rdata;
  endtask

  task automatic fetch(input int row, input int col, output logic [31:0] d);
    bus.vga_rd_en = 1'b1; bus.vga_row = 5'(row); bus.vga_col = 7'(col);
    tick();
    bus.vga_rd_en = 1'b0;
    d = bus.vga_char;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000 && bus.busy; k++) tick();
    if (bus.busy) check("wait_idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int cnt;
    bus.mem_write = 0; bus.addr = 0; bus.wdata = 0;
    bus.vga_rd_en = 0; bus.vga_row = 0; bus.vga_col = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_vga_valid", 32'(bus.vga_valid), 32'd0);
    check("rst_vga_char", bus.vga_char, 32'd0);
    check("rst_cursor_hit", 32'(bus.cursor_hit), 32'd0);
    rst = 1'b0;
    tick();

    // write then read back cell 5 and fetch it on the display port
    cpu_write(BASE + 32'd20, 32'h41);
    bus.vga_rd_en = 1'b1; bus.vga_row = 0; bus.vga_col = 5;
    tick();
    bus.vga_rd_en = 1'b0;
    check("cell5_rdata", bus.rdata, 32'h41);
    check("cell5_vga_valid", 32'(bus.vga_valid), 32'd1);
    check("cell5_vga_char", bus.vga_char, 32'h41);
    tick();
    check("vga_valid_drop", 32'(bus.vga_valid), 32'd0);

    // full clear: busy length, dropped write, FILL afterwards
    cpu_write(A_CTRL, 32'd1);
    cnt = 0;
    for (int k = 0; k < 3000 && bus.busy; k++) begin
      cnt++;
      if (k == 0) begin bus.mem_write = 1; bus.addr = BASE + 32'(4 * (N - 1)); bus.wdata = 32'h55; end
      else if (k == 5) cpu_write(A_CTRL, 32'd1);
      tick();
      bus.mem_write = 0;
      if (k == 5) cnt++;
    end
    check("clear_busy_cycles", 32'(cnt), 32'd2400);
    cpu_read(BASE + 32'(4 * (N - 1)), d);
    check("dropped_write", d, 32'h20);
    cpu_read(BASE + 32'd20, d);
    check("cell5_cleared", d, 32'h20);
    for (int i = 0; i < N; i++) begin bus.addr = BASE + 32'(4 * i); tick(); end

    // scroll wrap and rejected scroll value
    cpu_write(BASE + 32'd28, 32'h77);
    cpu_write(BASE + 32'(4 * (29 * COLS + 3)), 32'h99);
    cpu_write(A_SCROLL, 32'd29);
    fetch(1, 7, d);
    check("scroll29_row1", d, 32'h77);
    fetch(0, 3, d);
    check("scroll29_row0", d, 32'h99);
    cpu_write(A_SCROLL, 32'd30);
    cpu_read(A_SCROLL, d);
    check("scroll_reject", d, 32'd29);
    cpu_write(A_SCROLL, 32'd0);
    fetch(0, 100, d);
    check("col_out_of_range", d, 32'h20);
    fetch(31, 0, d);
    check("row_out_of_range", d, 32'h20);

    // read-before-write on the display port
    cpu_write(BASE + 32'd40, 32'hA1);
    bus.mem_write = 1; bus.addr = BASE + 32'd40; bus.wdata = 32'hB2;
    fetch(0, 10, d);
    bus.mem_write = 0;
    check("rbw_old", d, 32'hA1);
    fetch(0, 10, d);
    check("rbw_new", d, 32'hB2);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      bus.mem_write = ($urandom_range(0, 2) == 0);
      bus.wdata = $urandom;
      if (sel < 70)      bus.addr = BASE + 32'(4 * $urandom_range(0, N - 1));
      else if (sel < 80) begin bus.addr = A_SCROLL; bus.wdata = 32'($urandom_range(0, 40)); end
      else if (sel < 85) begin bus.addr = A_CURSOR; bus.wdata = 32'($urandom_range(0, N + 50)); end
      else if (sel < 90) begin bus.addr = A_CTRL; bus.wdata[0] = ($urandom_range(0, 400) == 0); end
      else if (sel < 95) bus.addr = BASE + 32'(4 * N + 12) + 32'($urandom_range(0, 64));
      else               bus.addr = BASE + 32'(4 * $urandom_range(0, N - 1)) + 32'($urandom_range(1, 3));
      bus.vga_rd_en = ($urandom_range(0, 1) == 1);
      bus.vga_row = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, ROWS - 1));
      bus.vga_col = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, COLS - 1));
      tick();
    end
    bus.mem_write = 0; bus.vga_rd_en = 0;
    wait_idle();
    cpu_write(A_SCROLL, 32'd0);

    // reset in the middle of a sweep
    cpu_write(BASE + 32'(4 * 99), 32'hCC);
    cpu_write(BASE + 32'(4 * 100), 32'hAA);
    cpu_write(BASE + 32'(4 * (N - 1)), 32'hBB);
    cpu_write(A_CTRL, 32'd1);
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    cpu_read(BASE + 32'(4 * 99), d);
    check("abort_cell99", d, 32'h20);
    cpu_read(BASE + 32'(4 * 100), d);
    check("abort_cell100", d, 32'hAA);
    cpu_read(BASE + 32'(4 * (N - 1)), d);
    check("abort_cell_last", d, 32'hBB);

    // cursor blink on cell 10
    cpu_write(A_CURSOR, 32'd10);
    cpu_read(A_CURSOR, d);
`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    check("cursor_reg", d, 32'd10);
`else
    check("cursor_reg", d, 32'd0);
`endif
    cnt = 0;
    bus.vga_rd_en = 1; bus.vga_row = 0; bus.vga_col = 10;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bus.cursor_hit) cnt++;
    end
    bus.vga_rd_en = 0;
`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    check("cursor_hit_count", 32'(cnt), 32'd8);
`else
    check("cursor_hit_count", 32'(cnt), 32'd0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
